mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares a single-ported unified memory between the processor's instruction-fetch port and its data (MEM-stage) port. Sits between the pipelined core and one memory array, replacing separate instruction and data memories. Arbitrates requests, sequences each access through a configurable number of wait states, and returns per-port ready pulses that the core's hazard logic uses as stall releases.

## Interface
- WAIT_STATES, 2, extra memory cycles per access beyond the first; legal range 0..15
- ADDR_W, 32, address width
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  instruction fetch request; held with if_addr until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  32  fetched word; held until the next instruction completion
- if_ready  out  1  one-cycle pulse: fetch complete, if_rdata valid
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ready
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  write data
- d_rdata  out  32  load data; held until the next data-read completion
- d_ready  out  1  one-cycle pulse: data access complete
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid combinationally while mem_en

## Operation
- States: IDLE, ACC. Registers: state, grant (INSTR/DATA), last_grant, cnt (4 bits), latched addr/we/wdata, if_rdata, d_rdata, if_ready, d_ready.
- IDLE: eligible = req high and that port's ready not high this cycle. Neither eligible: stay IDLE. One eligible: grant it. Both eligible: grant DATA unless last_grant = DATA, then grant INSTR (alternation prevents fetch starvation). On grant: latch address (and we/wdata for data), cnt <= WAIT_STATES, last_grant <= grant, go ACC.
- ACC: mem_en = 1, mem_addr/mem_wdata from latches. cnt > 0: decrement. cnt = 0: mem_we = latched we (writes strobe exactly one cycle); for reads capture mem_rdata into the granted port's rdata register; set granted port's ready for next cycle; go IDLE.
- Instruction port never writes; a data write does not alter d_rdata.
- Outside ACC: mem_en = 0, mem_we = 0; mem_addr/mem_wdata hold last latched values.
- Requests changing while not granted are ignored until sampled in IDLE; changing a granted request mid-access is a protocol violation (access uses latched values).

## Timing
- Reset (async, active-low): state IDLE, last_grant INSTR, cnt 0, all outputs 0 (mem_en, mem_we, if_ready, d_ready, rdata, mem_addr, mem_wdata). Reset mid-access abandons it: no ready, no write strobe after assertion.
- Request sampled in IDLE at cycle 0 -> ACC in cycles 1..WAIT_STATES+1 -> ready high in cycle WAIT_STATES+2 (state IDLE). Latency = WAIT_STATES+2; WAIT_STATES=0 gives a single ACC cycle, latency 2.
- mem_we high only in cycle WAIT_STATES+1.
- Ready cycle is also an arbitration cycle: the other port may be granted then; the port receiving ready is masked for that cycle only, so a held req is re-sampled next cycle as a new access.
- At most one ready high per cycle; ready never high in two consecutive cycles for the same port.

## Structure
- Shared package mem_arb_pkg: state enum (IDLE, ACC), grant enum (INSTR, DATA), default WAIT_STATES.
- One sub-module: mem_wait_cnt (load/decrement 4-bit counter with zero flag). Arbitration and datapath latches stay in mem_arbiter.

## Test plan
- Single fetch, WAIT_STATES=2: if_req, if_addr=0x10, memory word 0xE3A00005 -> mem_en cycles 1-3, if_ready in cycle 4, if_rdata=0xE3A00005, mem_we never high.
- Data write: d_req, d_we=1, d_addr=0x64, d_wdata=0x7 -> mem_we high in cycle 3 only, d_ready cycle 4, memory[0x64]=7, d_rdata unchanged.
- Simultaneous: both req held from reset -> order DATA, INSTR, DATA, INSTR, each 4 cycles apart; d_ready cycles 4, 12; if_ready cycles 8, 16.
- Held req after ready: if_req held alone -> ready every 5 cycles (masked ready cycle + 4), no duplicate within ready cycle.
- WAIT_STATES=0: data read 0x20 holding 0x55 -> one mem_en cycle, d_ready cycle 2, d_rdata=0x55.
- Reset asserted in cycle 2 of a write -> mem_en/mem_we drop immediately, no d_ready, memory unchanged; after release, grant resumes from IDLE with DATA preferred.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter between the
// instruction-fetch and data ports.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } arb_state_e;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } grant_e;

  localparam int DEFAULT_WAIT_STATES = 2;
  localparam int CNT_W               = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request/ready signals and the single memory port, bundled.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_ready;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ready, d_rdata, d_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_wait_cnt.sv
// Wait-state counter: loads on grant, counts down to zero during an access.
module mem_wait_cnt
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto one single-ported memory, running
// each access through WAIT_STATES extra cycles and pulsing a per-port ready.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES,
  parameter int ADDR_W      = 32
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_STATES);

  arb_state_e        state_q, state_d;
  grant_e            grant_q, grant_d;
  grant_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;

  logic if_elig, d_elig;
  logic cnt_load, cnt_dec, cnt_zero;

  mem_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (cnt_load),
    .load_val (WAIT_LD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_ready_d   = 1'b0;
    d_ready_d    = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    // A port is masked in its own ready cycle so a held request counts as new next cycle.
    if_elig      = bus.if_req && !if_ready_q;
    d_elig       = bus.d_req && !d_ready_q;

    case (state_q)
      IDLE: begin
        if (if_elig || d_elig) begin
          if (if_elig && d_elig) begin
            grant_d = (last_grant_q == DATA) ? INSTR : DATA;
          end else begin
            grant_d = d_elig ? DATA : INSTR;
          end
          if (grant_d == DATA) begin
            addr_d  = bus.d_addr;
            we_d    = bus.d_we;
            wdata_d = bus.d_wdata;
          end else begin
            addr_d  = bus.if_addr;
            we_d    = 1'b0;
          end
          last_grant_d = grant_d;
          cnt_load     = 1'b1;
          state_d      = ACC;
        end
      end
      ACC: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          if (!we_q) begin
            if (grant_q == DATA) d_rdata_d  = bus.mem_rdata;
            else                 if_rdata_d = bus.mem_rdata;
          end
          if (grant_q == DATA) d_ready_d  = 1'b1;
          else                 if_ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= INSTR;
      last_grant_q <= INSTR;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_ready_q   <= if_ready_d;
      d_ready_q    <= d_ready_d;
    end
  end

  // Strobes decode straight from registered state so an async reset drops them at once.
  assign bus.mem_en    = (state_q == ACC);
  assign bus.mem_we    = (state_q == ACC) && cnt_zero && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ready   = d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single accesses plus
// hand-written multi-cycle sequences (contention, held request, reset, WAIT_STATES=0).
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int LIMIT = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst0_n;
  int   errors = 0;
  int   checks = 0;

  mem_arbiter_if #(.ADDR_W(32)) bus ();
  mem_arbiter_if #(.ADDR_W(32)) bus0 ();

  mem_arbiter #(.WAIT_STATES(2), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  mem_arbiter #(.WAIT_STATES(0), .ADDR_W(32)) dut0 (
    .clk   (clk),
    .reset (rst0_n),
    .bus   (bus0)
  );

  // Memory model for the WAIT_STATES=2 instance, with a bench-side load port
  logic [31:0] mem [0:255];
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  assign bus.mem_rdata  = bus.mem_en ? mem[bus.mem_addr[7:0]] : 32'h0;
  assign bus0.mem_rdata = (bus0.mem_en && bus0.mem_addr == 32'h20) ? 32'h55 : 32'h0;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_reqs();
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  task automatic mem_load(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic do_reset();
    clear_reqs();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    clear_reqs();
    repeat (n) @(negedge clk);
  endtask

  // One access from idle; cycle 0 is the negedge where the request is raised.
  task automatic run_vec(input vec_t v, input int idx);
    int rdy_cyc;
    int other;
    int en_cnt;
    int we_cnt;
    int we_cyc;
    rdy_cyc = -1;
    other   = 0;
    en_cnt  = 0;
    we_cnt  = 0;
    we_cyc  = 0;
    @(negedge clk);
    if (v.is_d) begin
      bus.d_req   = 1'b1;
      bus.d_we    = v.we;
      bus.d_addr  = v.addr;
      bus.d_wdata = v.wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end
    for (int c = 1; c <= LIMIT && rdy_cyc < 0; c++) begin
      @(negedge clk);
      if (bus.mem_en) en_cnt++;
      if (bus.mem_we) begin
        we_cnt++;
        we_cyc = c;
      end
      if (v.is_d ? bus.d_ready : bus.if_ready) rdy_cyc = c;
      if (v.is_d ? bus.if_ready : bus.d_ready) other++;
    end
    clear_reqs();
    check($sformatf("v%0d ready_cycle", idx), 32'(rdy_cyc), 32'd4);
    check($sformatf("v%0d mem_en_cycles", idx), 32'(en_cnt), 32'd3);
    check($sformatf("v%0d mem_we_count", idx), 32'(we_cnt), v.we ? 32'd1 : 32'd0);
    check($sformatf("v%0d mem_we_cycle", idx), 32'(we_cyc), v.we ? 32'd3 : 32'd0);
    check($sformatf("v%0d other_ready", idx), 32'(other), 32'd0);
    check($sformatf("v%0d if_rdata", idx), bus.if_rdata, v.exp_if_rdata);
    check($sformatf("v%0d d_rdata", idx), bus.d_rdata, v.exp_d_rdata);
    check($sformatf("v%0d mem_addr_hold", idx), bus.mem_addr, v.addr);
    @(negedge clk);
    check($sformatf("v%0d memory", idx), mem[v.addr[7:0]], v.exp_mem);
    $display("txn %0d: %s %s addr=0x%08h ready@%0d if_rdata=0x%08h d_rdata=0x%08h",
             idx, v.is_d ? "DATA" : "INSTR", v.we ? "W" : "R", v.addr, rdy_cyc,
             bus.if_rdata, bus.d_rdata);
  endtask

  initial begin
    int          d_c [4];
    int          i_c [4];
    int          nd;
    int          ni;
    int          both;
    logic [31:0] order [4];
    int          h_c [4];
    int          nh;
    int          en0;

    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hE3A00005, 32'h0,        32'hE3A00005};
    vecs[1] = '{1'b1, 1'b1, 32'h64, 32'h7,        32'hE3A00005, 32'h0,        32'h7};
    vecs[2] = '{1'b1, 1'b0, 32'h64, 32'h0,        32'hE3A00005, 32'h7,        32'h7};
    vecs[3] = '{1'b0, 1'b0, 32'h20, 32'h0,        32'h12345678, 32'h7,        32'h12345678};
    vecs[4] = '{1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 32'h12345678, 32'h7,        32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'h12345678, 32'hE3A00005, 32'hE3A00005};
    vecs[6] = '{1'b0, 1'b0, 32'h20, 32'h0,        32'hCAFEF00D, 32'hE3A00005, 32'hCAFEF00D};

    rst_n   = 1'b0;
    rst0_n  = 1'b0;
    ld_en   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    clear_reqs();
    bus0.if_req  = 1'b0;
    bus0.if_addr = '0;
    bus0.d_req   = 1'b0;
    bus0.d_we    = 1'b0;
    bus0.d_addr  = '0;
    bus0.d_wdata = '0;
    repeat (2) @(negedge clk);

    check("reset mem_en",    32'(bus.mem_en),   32'h0);
    check("reset mem_we",    32'(bus.mem_we),   32'h0);
    check("reset if_ready",  32'(bus.if_ready), 32'h0);
    check("reset d_ready",   32'(bus.d_ready),  32'h0);
    check("reset if_rdata",  bus.if_rdata,      32'h0);
    check("reset d_rdata",   bus.d_rdata,       32'h0);
    check("reset mem_addr",  bus.mem_addr,      32'h0);
    check("reset mem_wdata", bus.mem_wdata,     32'h0);
    rst_n  = 1'b1;
    rst0_n = 1'b1;

    mem_load(8'h10, 32'hE3A00005);
    mem_load(8'h64, 32'h0);
    mem_load(8'h20, 32'h12345678);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Both requests held from reset: DATA, INSTR, DATA, INSTR
    do_reset();
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h64;
    nd = 0; ni = 0; both = 0;
    for (int k = 0; k < 4; k++) begin
      d_c[k] = -1; i_c[k] = -1; order[k] = '1;
    end
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (bus.d_ready && nd < 4) begin d_c[nd] = c; nd++; end
      if (bus.if_ready && ni < 4) begin i_c[ni] = c; ni++; end
      if (bus.d_ready && bus.if_ready) both++;
      if ((c % 4) == 1 && c <= 13) order[(c - 1) / 4] = bus.mem_addr;
    end
    drain(6);
    check("contend d_ready count", 32'(nd), 32'd2);
    check("contend d_ready #1", 32'(d_c[0]), 32'd4);
    check("contend d_ready #2", 32'(d_c[1]), 32'd12);
    check("contend if_ready count", 32'(ni), 32'd2);
    check("contend if_ready #1", 32'(i_c[0]), 32'd8);
    check("contend if_ready #2", 32'(i_c[1]), 32'd16);
    check("contend both_ready", 32'(both), 32'd0);
    check("contend grant1", order[0], 32'h64);
    check("contend grant2", order[1], 32'h10);
    check("contend grant3", order[2], 32'h64);
    check("contend grant4", order[3], 32'h10);
    $display("txn contend: d_ready@%0d,%0d if_ready@%0d,%0d", d_c[0], d_c[1], i_c[0], i_c[1]);

    // Held fetch request alone: ready every 5 cycles
    do_reset();
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    nh = 0;
    for (int k = 0; k < 4; k++) h_c[k] = -1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (bus.if_ready) begin
        if (nh < 4) h_c[nh] = c;
        nh++;
      end
    end
    drain(6);
    check("held ready count", 32'(nh), 32'd3);
    check("held ready #1", 32'(h_c[0]), 32'd4);
    check("held ready #2", 32'(h_c[1]), 32'd9);
    check("held ready #3", 32'(h_c[2]), 32'd14);
    $display("txn held: if_ready@%0d,%0d,%0d", h_c[0], h_c[1], h_c[2]);

    // Reset in cycle 2 of a write abandons it; DATA wins first after release
    do_reset();
    mem_load(8'h30, 32'h1111);
    @(negedge clk);
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h30;
    bus.d_wdata = 32'hDEAD;
    @(negedge clk);
    check("rstmid cycle1 mem_en", 32'(bus.mem_en), 32'h1);
    @(negedge clk);
    check("rstmid cycle2 mem_en", 32'(bus.mem_en), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rstmid mem_en drop", 32'(bus.mem_en), 32'h0);
    check("rstmid mem_we drop", 32'(bus.mem_we), 32'h0);
    nd = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.d_ready || bus.mem_we) nd++;
    end
    check("rstmid no ready/strobe", 32'(nd), 32'd0);
    check("rstmid memory kept", mem[8'h30], 32'h1111);
    rst_n       = 1'b1;
    bus.d_we    = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    @(negedge clk);
    check("rstmid resume grant DATA", bus.mem_addr, 32'h30);
    repeat (3) @(negedge clk);
    check("rstmid resume d_ready", 32'(bus.d_ready), 32'h1);
    check("rstmid resume d_rdata", bus.d_rdata, 32'h1111);
    drain(6);
    $display("txn rstmid: write abandoned, resumed read d_rdata=0x%08h", bus.d_rdata);

    // WAIT_STATES=0 instance: one ACC cycle, latency 2
    @(negedge clk);
    bus0.d_req  = 1'b1;
    bus0.d_we   = 1'b0;
    bus0.d_addr = 32'h20;
    en0 = 0;
    @(negedge clk);
    if (bus0.mem_en) en0++;
    check("ws0 cycle1 d_ready", 32'(bus0.d_ready), 32'h0);
    @(negedge clk);
    if (bus0.mem_en) en0++;
    check("ws0 cycle2 d_ready", 32'(bus0.d_ready), 32'h1);
    check("ws0 d_rdata", bus0.d_rdata, 32'h55);
    bus0.d_req = 1'b0;
    @(negedge clk);
    if (bus0.mem_en) en0++;
    check("ws0 no repeat ready", 32'(bus0.d_ready), 32'h0);
    check("ws0 mem_en cycles", 32'(en0), 32'd1);
    $display("txn ws0: read 0x20 d_rdata=0x%08h mem_en_cycles=%0d", bus0.d_rdata, en0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
